// File: rtl/arm_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : arm_hazard_unit
// Purpose : Operand forwarding selects, load-use stall, SWI drain/halt and
//           stall counter for the 5-stage ARM pipeline.
// Revision: 1.0 - initial release
// ============================================================================
module arm_hazard_unit #(
  parameter int CNT_W  = 32,
  parameter int FWD_WB = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             id_valid,
  input  logic [2:0]       id_mask,
  input  logic [3:0]       id_rn0,
  input  logic [3:0]       id_rn1,
  input  logic [3:0]       id_rn2,
  input  logic             id_rd_we,
  input  logic [3:0]       id_rd_num,
  input  logic             id_is_load,
  input  logic             id_swi,
  input  logic             ex_flush,
  output logic             stall_id,
  output logic [1:0]       fwd_sel0,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic       we;
    logic [3:0] rd;
    logic       ld;
    logic       swi;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  slot_t      ex_slot, mem_slot, wb_slot, id_slot;
  logic [3:0] rn [3];
  logic [1:0] sel [3];
  logic [2:0] ex_hit, mem_hit, wb_hit;
  logic       lu, accept, drain;
  logic       unused_wb_ld;

  assign rn[0] = id_rn0;
  assign rn[1] = id_rn1;
  assign rn[2] = id_rn2;

  // r15 reads the PC, never a forwarded result; youngest writer wins
  for (genvar k = 0; k < 3; k++) begin : g_op
    logic live;
    assign live       = id_mask[k] & (rn[k] != 4'd15);
    assign ex_hit[k]  = live & ex_slot.v  & ex_slot.we  & (ex_slot.rd  == rn[k]);
    assign mem_hit[k] = live & mem_slot.v & mem_slot.we & (mem_slot.rd == rn[k]);
    assign wb_hit[k]  = live & wb_slot.v  & wb_slot.we  & (wb_slot.rd  == rn[k]);
    assign sel[k]     = ex_hit[k]                     ? 2'd1 :
                        mem_hit[k]                    ? 2'd2 :
                        (wb_hit[k] && (FWD_WB != 0))  ? 2'd3 : 2'd0;
  end

  assign fwd_sel0 = sel[0];
  assign fwd_sel1 = sel[1];
  assign fwd_sel2 = sel[2];

  assign lu       = id_valid & ~ex_flush & ex_slot.ld & (|ex_hit);
  assign stall_id = lu | drain;
  assign accept   = id_valid & ~stall_id & ~ex_flush;

  assign id_slot  = '{v: 1'b1, we: id_rd_we, rd: id_rd_num, ld: id_is_load, swi: id_swi};
  assign unused_wb_ld = wb_slot.ld;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ex_slot   <= '0;
      mem_slot  <= '0;
      wb_slot   <= '0;
      drain     <= 1'b0;
      halted    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      ex_slot   <= accept ? id_slot : '0;
      mem_slot  <= ex_slot;
      wb_slot   <= mem_slot;
      drain     <= drain | (accept & id_swi);
      halted    <= halted | (wb_slot.v & wb_slot.swi);
      if (lu && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arm_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_arm_hazard_unit
// Purpose : Directed self-checking bench; one instance forwards from WB, the
//           other does not and has a 2-bit counter to exercise saturation.
// Revision: 1.0 - initial release
// ============================================================================
module tb_arm_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        id_valid;
  logic [2:0]  id_mask;
  logic [3:0]  id_rn0, id_rn1, id_rn2;
  logic        id_rd_we;
  logic [3:0]  id_rd_num;
  logic        id_is_load, id_swi, ex_flush;

  logic        stall_a, halted_a;
  logic [1:0]  sel0_a, sel1_a, sel2_a;
  logic [31:0] cnt_a;
  logic        stall_b, halted_b;
  logic [1:0]  sel0_b, sel1_b, sel2_b;
  logic [1:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arm_hazard_unit #(.CNT_W(32), .FWD_WB(1)) dut_a (
    .clk(clk), .rst_b(rst_b), .id_valid(id_valid), .id_mask(id_mask),
    .id_rn0(id_rn0), .id_rn1(id_rn1), .id_rn2(id_rn2), .id_rd_we(id_rd_we),
    .id_rd_num(id_rd_num), .id_is_load(id_is_load), .id_swi(id_swi),
    .ex_flush(ex_flush), .stall_id(stall_a), .fwd_sel0(sel0_a),
    .fwd_sel1(sel1_a), .fwd_sel2(sel2_a), .halted(halted_a), .stall_cnt(cnt_a)
  );

  arm_hazard_unit #(.CNT_W(2), .FWD_WB(0)) dut_b (
    .clk(clk), .rst_b(rst_b), .id_valid(id_valid), .id_mask(id_mask),
    .id_rn0(id_rn0), .id_rn1(id_rn1), .id_rn2(id_rn2), .id_rd_we(id_rd_we),
    .id_rd_num(id_rd_num), .id_is_load(id_is_load), .id_swi(id_swi),
    .ex_flush(ex_flush), .stall_id(stall_b), .fwd_sel0(sel0_b),
    .fwd_sel1(sel1_b), .fwd_sel2(sel2_b), .halted(halted_b), .stall_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge, leaving inputs free to change 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] m, input logic [3:0] r0,
                        input logic [3:0] r1, input logic [3:0] r2, input logic we,
                        input logic [3:0] rd, input logic ld, input logic swi,
                        input logic fl);
    id_valid = v;  id_mask = m; id_rn0 = r0; id_rn1 = r1; id_rn2 = r2;
    id_rd_we = we; id_rd_num = rd; id_is_load = ld; id_swi = swi; ex_flush = fl;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_b = 1'b0;
    idle();
    step(); step();
    #1;
    check("rst_stall",  32'(stall_a),  32'd0);
    check("rst_sel0",   32'(sel0_a),   32'd0);
    check("rst_halted", 32'(halted_a), 32'd0);
    check("rst_cnt",    cnt_a,         32'd0);
    rst_b = 1'b1;
    step();

    // ADD r1,r2,r3 ; SUB r4,r1,r5
    set_id(1, 3'b011, 4'd2, 4'd3, 4'd0, 1, 4'd1, 0, 0, 0);
    step();
    set_id(1, 3'b011, 4'd1, 4'd5, 4'd0, 1, 4'd4, 0, 0, 0);
    check("add_sub_sel0",  32'(sel0_a),  32'd1);
    check("add_sub_sel1",  32'(sel1_a),  32'd0);
    check("add_sub_stall", 32'(stall_a), 32'd0);
    step();

    // LDR r2,[r0] ; ADD r6,r2,r7
    set_id(1, 3'b001, 4'd0, 4'd0, 4'd0, 1, 4'd2, 1, 0, 0);
    check("ldr_no_hit", 32'(sel0_a), 32'd0);
    step();
    set_id(1, 3'b011, 4'd2, 4'd7, 4'd0, 1, 4'd6, 0, 0, 0);
    check("lu_stall", 32'(stall_a), 32'd1);
    check("lu_sel0",  32'(sel0_a),  32'd1);
    check("lu_cnt0",  cnt_a,        32'd0);
    step();
    check("lu_cnt1",   cnt_a,        32'd1);
    check("lu_stall2", 32'(stall_a), 32'd0);
    check("lu_sel0_2", 32'(sel0_a),  32'd2);
    check("lu_sel1_2", 32'(sel1_a),  32'd0);
    step();

    // three MOV r3 then ORR r8,r3,r3 (rn2=r3 masked off)
    set_id(1, 3'b000, 4'd0, 4'd0, 4'd0, 1, 4'd3, 0, 0, 0);
    step(); step(); step();
    set_id(1, 3'b011, 4'd3, 4'd3, 4'd3, 1, 4'd8, 0, 0, 0);
    check("young_sel0", 32'(sel0_a), 32'd1);
    check("young_sel1", 32'(sel1_a), 32'd1);
    check("mask_sel2",  32'(sel2_a), 32'd0);
    idle();
    step();
    set_id(1, 3'b011, 4'd3, 4'd3, 4'd0, 1, 4'd8, 0, 0, 0);
    check("mem_sel0", 32'(sel0_a), 32'd2);
    idle();
    step();
    set_id(1, 3'b011, 4'd3, 4'd3, 4'd0, 1, 4'd8, 0, 0, 0);
    check("wb_sel0_fwd",   32'(sel0_a), 32'd3);
    check("wb_sel1_fwd",   32'(sel1_a), 32'd3);
    check("wb_sel0_nofwd", 32'(sel0_b), 32'd0);
    idle();
    step();

    // masked operand and r15
    set_id(1, 3'b000, 4'd0, 4'd0, 4'd0, 1, 4'd1, 0, 0, 0);
    step();
    set_id(1, 3'b110, 4'd1, 4'd0, 4'd0, 1, 4'd15, 0, 0, 0);
    check("masked_sel0", 32'(sel0_a), 32'd0);
    step();
    set_id(1, 3'b011, 4'd15, 4'd1, 4'd0, 0, 4'd0, 0, 0, 0);
    check("r15_sel0", 32'(sel0_a), 32'd0);
    check("r1_mem",   32'(sel1_a), 32'd2);
    idle();
    step();

    // load-use hazard killed by a flush
    set_id(1, 3'b000, 4'd0, 4'd0, 4'd0, 1, 4'd2, 1, 0, 0);
    step();
    set_id(1, 3'b001, 4'd2, 4'd0, 4'd0, 1, 4'd6, 0, 0, 1);
    check("flush_stall", 32'(stall_a), 32'd0);
    step();
    set_id(1, 3'b001, 4'd6, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0);
    check("flush_bubble", 32'(sel0_a), 32'd0);
    check("flush_cnt",    cnt_a,        32'd1);
    idle();
    step();

    // three more load-use stalls: 32-bit counter reaches 4, 2-bit saturates at 3
    for (int i = 0; i < 3; i++) begin
      set_id(1, 3'b000, 4'd0, 4'd0, 4'd0, 1, 4'd2, 1, 0, 0);
      step();
      set_id(1, 3'b001, 4'd2, 4'd0, 4'd0, 1, 4'd6, 0, 0, 0);
      step(); step();
    end
    idle();
    check("cnt_four", cnt_a,        32'd4);
    check("cnt_sat",  32'(cnt_b),   32'd3);
    step(); step(); step();

    // flushed SWI does not drain
    set_id(1, 3'b000, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 1);
    step();
    idle();
    check("swi_flushed", 32'(stall_a), 32'd0);

    // SWI accepted at edge t
    set_id(1, 3'b000, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 0);
    step();
    set_id(1, 3'b000, 4'd0, 4'd0, 4'd0, 1, 4'd9, 0, 0, 0);
    check("drain_stall", 32'(stall_a), 32'd1);
    step();
    check("halt_t1", 32'(halted_a), 32'd0);
    step();
    check("halt_t2", 32'(halted_a), 32'd0);
    set_id(1, 3'b001, 4'd9, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0);
    check("drain_no_accept", 32'(sel0_a), 32'd0);
    check("drain_stall2",    32'(stall_a), 32'd1);
    step();
    check("halt_t3",   32'(halted_a), 32'd1);
    check("drain_cnt", cnt_a,         32'd4);
    step();
    check("halt_sticky", 32'(halted_a), 32'd1);

    rst_b = 1'b0;
    step();
    check("rst2_halted", 32'(halted_a), 32'd0);
    check("rst2_stall",  32'(stall_a),  32'd0);
    check("rst2_cnt",    cnt_a,         32'd0);
    check("rst2_cnt_b",  32'(cnt_b),    32'd0);
    rst_b = 1'b1;
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
